// File: rtl/usb_nrzi_eop_encoder.sv
// usb_nrzi_eop_encoder
//
// NRZI line encoder with end-of-packet generation for a USB full/low-speed
// transmitter. It takes stuffed serial bits and drives the D+/D- lines. A 0 bit
// toggles the line between J and K, and a 1 bit holds it. A sendEOP request
// ends the packet with SE0, SE0, J and then releases the bus.
//
// Parameters:
//   USE_LOW_SPEED - 0: full-speed polarity (J = P1/N0), 1: low-speed polarity (J = P0/N1)
// Ports:
//   clk12     - 12 MHz bit clock, rising edge
//   RST       - synchronous active-high reset
//   txActive  - dataIn holds a valid stuffed bit this cycle
//   dataIn    - stuffed serial bit
//   sendEOP   - single-cycle request to terminate the current packet
//   outEN     - transceiver output enable
//   dataOutP  - D+ level
//   dataOutN  - D- level
//   busy      - high in any state other than idle
//   eopDone   - one-cycle pulse in the first idle cycle after the EOP
//
// All outputs are registered. They are computed from the next state, so a bit
// sampled on an edge is on the line from that edge to the next one.

module usb_nrzi_eop_encoder #(
    parameter bit USE_LOW_SPEED = 1'b0
) (
    input  logic clk12,
    input  logic RST,
    input  logic txActive,
    input  logic dataIn,
    input  logic sendEOP,
    output logic outEN,
    output logic dataOutP,
    output logic dataOutN,
    output logic busy,
    output logic eopDone
);

    typedef enum logic [2:0] {
        StIdle,
        StTx,
        StEopSe0a,
        StEopSe0b,
        StEopJ
    } state_e;

    // Line levels for J. K is the complement. SE0 drives both lines low.
    localparam logic JP = USE_LOW_SPEED ? 1'b0 : 1'b1;
    localparam logic JN = ~JP;

    state_e state_q, state_d;
    logic   level_k_q, level_k_d;     // NRZI level: 0 = J, 1 = K
    logic   out_en_d, p_d, n_d, busy_d, eop_done_d;
    logic   line_k, se0;

    // Next-state and NRZI level.
    always_comb begin
        state_d   = state_q;
        level_k_d = level_k_q;
        unique case (state_q)
            StIdle: begin
                level_k_d = 1'b0;
                if (txActive) begin
                    state_d   = StTx;
                    level_k_d = ~dataIn;   // first bit is encoded against J
                end
            end
            StTx: begin
                // sendEOP wins over txActive. The bit offered that cycle is dropped.
                if (sendEOP) begin
                    state_d = StEopSe0a;
                end else if (txActive) begin
                    level_k_d = dataIn ? level_k_q : ~level_k_q;
                end
            end
            StEopSe0a: state_d = StEopSe0b;
            StEopSe0b: state_d = StEopJ;
            StEopJ: begin
                state_d   = StIdle;
                level_k_d = 1'b0;
            end
            default: begin
                state_d   = StIdle;
                level_k_d = 1'b0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        out_en_d   = (state_d != StIdle);
        busy_d     = (state_d != StIdle);
        se0        = (state_d == StEopSe0a) || (state_d == StEopSe0b);
        // The line carries the NRZI level only while transmitting. Otherwise it is J.
        line_k     = (state_d == StTx) ? level_k_d : 1'b0;
        p_d        = se0 ? 1'b0 : (line_k ? JN : JP);
        n_d        = se0 ? 1'b0 : (line_k ? JP : JN);
        eop_done_d = (state_q == StEopJ);
    end

    always_ff @(posedge clk12) begin
        if (RST) begin
            state_q   <= StIdle;
            level_k_q <= 1'b0;
            outEN     <= 1'b0;
            dataOutP  <= JP;
            dataOutN  <= JN;
            busy      <= 1'b0;
            eopDone   <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_k_q <= level_k_d;
            outEN     <= out_en_d;
            dataOutP  <= p_d;
            dataOutN  <= n_d;
            busy      <= busy_d;
            eopDone   <= eop_done_d;
        end
    end

endmodule

// File: tb/tb_usb_nrzi_eop_encoder.sv
// Self-checking bench for usb_nrzi_eop_encoder. It drives one full-speed
// instance and one low-speed instance from the same stimulus. Both are
// compared with a packet-level model that emits line symbols (J, K, SE0),
// together with the directed line patterns for SYNC, stall, priority and
// reset cases.

module tb_usb_nrzi_eop_encoder;

    logic clk12 = 1'b0;
    logic RST = 1'b1, txActive = 1'b0, dataIn = 1'b0, sendEOP = 1'b0;
    logic en_fs, p_fs, n_fs, busy_fs, done_fs;
    logic en_ls, p_ls, n_ls, busy_ls, done_ls;
    logic [4:0] obs_fs, obs_ls;

    int checks = 0;
    int failures = 0;

    always #5 clk12 = ~clk12;

    usb_nrzi_eop_encoder #(.USE_LOW_SPEED(1'b0)) dut_fs (
        .clk12(clk12), .RST(RST), .txActive(txActive), .dataIn(dataIn), .sendEOP(sendEOP),
        .outEN(en_fs), .dataOutP(p_fs), .dataOutN(n_fs), .busy(busy_fs), .eopDone(done_fs)
    );

    usb_nrzi_eop_encoder #(.USE_LOW_SPEED(1'b1)) dut_ls (
        .clk12(clk12), .RST(RST), .txActive(txActive), .dataIn(dataIn), .sendEOP(sendEOP),
        .outEN(en_ls), .dataOutP(p_ls), .dataOutN(n_ls), .busy(busy_ls), .eopDone(done_ls)
    );

    assign obs_fs = {en_fs, p_fs, n_fs, busy_fs, done_fs};
    assign obs_ls = {en_ls, p_ls, n_ls, busy_ls, done_ls};

    // ---------------- reference model ----------------
    localparam int SYM_J = 0, SYM_K = 1, SYM_SE0 = 2;
    localparam int Q_SE0 = 0, Q_J = 1, Q_DONE = 2;

    bit m_in_pkt = 0;
    bit m_k = 0;
    int m_q[$];
    int m_sym = SYM_J;
    bit m_en = 0, m_busy = 0, m_done = 0;

    // Works out what the line shows after the coming edge, from the USB rules:
    // NRZI toggles on 0, each packet starts from J, the EOP is SE0 SE0 J and is
    // followed by an idle cycle that carries the done pulse.
    task automatic model_step(input bit r, input bit t, input bit d, input bit e);
        int s;
        m_done = 0;
        if (r) begin
            m_in_pkt = 0; m_k = 0; m_q.delete();
            m_sym = SYM_J; m_en = 0; m_busy = 0;
        end else if (m_q.size() > 0) begin
            s = m_q.pop_front();
            if (s == Q_SE0) begin
                m_sym = SYM_SE0; m_en = 1; m_busy = 1;
            end else if (s == Q_J) begin
                m_sym = SYM_J; m_en = 1; m_busy = 1;
            end else begin
                m_sym = SYM_J; m_en = 0; m_busy = 0; m_done = 1;
                m_in_pkt = 0; m_k = 0;
            end
        end else if (m_in_pkt) begin
            if (e) begin
                m_sym = SYM_SE0;
                m_q.push_back(Q_SE0); m_q.push_back(Q_J); m_q.push_back(Q_DONE);
            end else if (t) begin
                if (!d) m_k = !m_k;
                m_sym = m_k ? SYM_K : SYM_J;
            end
        end else if (t) begin
            m_in_pkt = 1; m_k = !d;
            m_sym = m_k ? SYM_K : SYM_J; m_en = 1; m_busy = 1;
        end else begin
            m_sym = SYM_J; m_en = 0; m_busy = 0;
        end
    endtask

    function automatic logic [4:0] expv(input bit ls);
        logic p, n;
        if (m_sym == SYM_SE0) begin
            p = 0; n = 0;
        end else begin
            p = ((m_sym == SYM_J) != ls);
            n = !p;
        end
        return {m_en, p, n, m_busy, m_done};
    endfunction

    // Applies inputs for one cycle, advances the model and samples 1 ns after the edge.
    task automatic step(input bit r, input bit t, input bit d, input bit e);
        RST = r; txActive = t; dataIn = d; sendEOP = e;
        model_step(r, t, d, e);
        @(posedge clk12);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        checks += 2;
        if (obs_fs !== 5'b01000) begin
            failures++; $display("FAIL reset_fs got=%b exp=01000", obs_fs);
        end
        if (obs_ls !== 5'b00100) begin
            failures++; $display("FAIL reset_ls got=%b exp=00100", obs_ls);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_sync_eop();
        logic [7:0] sync_bits = 8'b1000_0000;     // bit i is sent in cycle i
        logic [7:0] fs_p      = 8'b0010_1010;     // K,J,K,J,K,J,K,K as D+ (FS)
        logic [2:0] tail_bits = 3'b011;           // 1,1,0
        logic [2:0] tail_p    = 3'b100;           // K,K,J
        for (int i = 0; i < 8; i++) begin
            step(0, 1, sync_bits[i], 0);
            checks += 3;
            if ({en_fs, p_fs, n_fs} !== {1'b1, fs_p[i], ~fs_p[i]}) begin
                failures++;
                $display("FAIL sync_fs i=%0d got=%b exp=%b", i, {en_fs, p_fs, n_fs},
                         {1'b1, fs_p[i], ~fs_p[i]});
            end
            if ({en_ls, p_ls, n_ls} !== {1'b1, ~fs_p[i], fs_p[i]}) begin
                failures++;
                $display("FAIL sync_ls i=%0d got=%b exp=%b", i, {en_ls, p_ls, n_ls},
                         {1'b1, ~fs_p[i], fs_p[i]});
            end
            if (obs_fs !== expv(0)) begin
                failures++; $display("FAIL sync_model i=%0d got=%b exp=%b", i, obs_fs, expv(0));
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, tail_bits[i], 0);
            checks++;
            if ({p_fs, n_fs} !== {tail_p[i], ~tail_p[i]}) begin
                failures++;
                $display("FAIL tail_fs i=%0d got=%b exp=%b", i, {p_fs, n_fs}, {tail_p[i], ~tail_p[i]});
            end
        end
        // EOP: SE0, SE0, J (outputs en,p,n,busy,done), then idle with the done pulse, then quiet.
        begin
            logic [4:0] eop_exp [5] = '{5'b10010, 5'b10010, 5'b11010, 5'b01001, 5'b01000};
            for (int i = 0; i < 5; i++) begin
                step(0, 0, 0, (i == 0));
                checks += 2;
                if (obs_fs !== eop_exp[i]) begin
                    failures++; $display("FAIL eop_fs i=%0d got=%b exp=%b", i, obs_fs, eop_exp[i]);
                end
                if (obs_ls !== expv(1)) begin
                    failures++; $display("FAIL eop_ls i=%0d got=%b exp=%b", i, obs_ls, expv(1));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] st_p = 4'b1000;   // K,K,K,J as D+ (FS), bit i in cycle i
        step(0, 1, 0, 0);             // J -> K
        for (int i = 0; i < 4; i++) begin
            step(0, (i == 3), 0, 0);
            checks++;
            if ({en_fs, p_fs, n_fs} !== {1'b1, st_p[i], ~st_p[i]}) begin
                failures++;
                $display("FAIL stall i=%0d got=%b exp=%b", i, {en_fs, p_fs, n_fs},
                         {1'b1, st_p[i], ~st_p[i]});
            end
        end
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        checks++;
        if (obs_fs !== expv(0)) begin
            failures++; $display("FAIL stall_end got=%b exp=%b", obs_fs, expv(0));
        end
    endtask

    task automatic test_eop_priority();
        step(0, 1, 1, 0);             // line J
        step(0, 1, 0, 1);             // bit must be dropped, SE0 instead of toggle
        checks++;
        if (obs_fs !== 5'b10010) begin
            failures++; $display("FAIL eop_prio got=%b exp=10010", obs_fs);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        // sendEOP alone while idle is ignored
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, (i == 0));
            checks++;
            if (obs_fs !== 5'b01000) begin
                failures++; $display("FAIL eop_idle i=%0d got=%b exp=01000", i, obs_fs);
            end
        end
    endtask

    task automatic test_reset_mid_eop();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);             // now in SE0A
        step(0, 0, 0, 0);             // now in SE0B
        step(1, 1, 0, 1);
        checks += 2;
        if (obs_fs !== 5'b01000) begin
            failures++; $display("FAIL rst_eop_fs got=%b exp=01000", obs_fs);
        end
        if (obs_ls !== 5'b00100) begin
            failures++; $display("FAIL rst_eop_ls got=%b exp=00100", obs_ls);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            checks++;
            if (done_fs !== 1'b0 || en_fs !== 1'b0) begin
                failures++;
                $display("FAIL rst_eop_nodone i=%0d got=%b%b exp=00", i, en_fs, done_fs);
            end
        end
    endtask

    task automatic test_random();
        bit r, t, d, e;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 39) == 0);
            t = ($urandom_range(0, 9) < 7);
            d = $urandom_range(0, 1);
            e = ($urandom_range(0, 13) == 0);
            step(r, t, d, e);
            checks += 3;
            if (obs_fs !== expv(0)) begin
                failures++; $display("FAIL rand_fs i=%0d got=%b exp=%b", i, obs_fs, expv(0));
            end
            if (obs_ls !== expv(1)) begin
                failures++; $display("FAIL rand_ls i=%0d got=%b exp=%b", i, obs_ls, expv(1));
            end
            if ((p_fs & n_fs) !== 1'b0 || (p_ls & n_ls) !== 1'b0) begin
                failures++;
                $display("FAIL rand_se1 i=%0d got=%b%b%b%b exp=no_se1", i, p_fs, n_fs, p_ls, n_ls);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync_eop();
        test_stall();
        test_eop_priority();
        test_reset_mid_eop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_nrzi_eop_encoder.md
USB_NRZI_EOP_ENCODER -- requirements
Module: usb_nrzi_eop_encoder

Interface
REQ-001 Parameter: USE_LOW_SPEED, default 0; meaning: 0 = full-speed line polarity (J: P=1,N=0; K: P=0,N=1), 1 = low-speed polarity (J: P=0,N=1; K: P=1,N=0).
REQ-002 clk12  input  1  12 MHz bit clock; all state changes on its rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 txActive  input  1  dataIn carries a valid stuffed bit this cycle.
REQ-005 dataIn  input  1  stuffed serial bit from the upstream bit stuffer, LSB-first order already applied.
REQ-006 sendEOP  input  1  single-cycle request to terminate the current packet.
REQ-007 outEN  output  1  transceiver output enable; 1 while driving the bus.
REQ-008 dataOutP  output  1  D+ line level.
REQ-009 dataOutN  output  1  D- line level.
REQ-010 busy  output  1  1 in any state other than IDLE.
REQ-011 eopDone  output  1  single-cycle pulse when the EOP sequence completes.

Function
REQ-012 The block SHALL implement states IDLE, TX, EOP_SE0A, EOP_SE0B, EOP_J.
REQ-013 All outputs SHALL be registered; a bit sampled at edge N is on the line from edge N until edge N+1 (latency 1 cycle from input to line).
REQ-014 IDLE: outEN=0, line = J, busy=0; internal NRZI level register = J.
REQ-015 IDLE with txActive=1 -> TX; the bit sampled on that edge SHALL be encoded against level J.
REQ-016 IDLE with sendEOP=1 and txActive=0: request ignored, remain IDLE, eopDone=0.
REQ-017 NRZI rule in TX: dataIn=0 -> line toggles J<->K; dataIn=1 -> line holds previous level.
REQ-018 TX with txActive=0 and sendEOP=0: stall; line holds last level, outEN stays 1, NRZI level unchanged.
REQ-019 TX with sendEOP=1 -> EOP_SE0A regardless of txActive; dataIn that cycle SHALL be discarded (sendEOP has priority).
REQ-020 EOP_SE0A and EOP_SE0B: dataOutP=0, dataOutN=0 (SE0), outEN=1, one cycle each.
REQ-021 EOP_J: line = J, outEN=1, one cycle; next state IDLE.
REQ-022 eopDone SHALL be 1 exactly in the cycle after EOP_J (first IDLE cycle), 0 otherwise.
REQ-023 txActive and sendEOP SHALL be ignored during EOP_SE0A, EOP_SE0B, EOP_J.
REQ-024 NRZI level register SHALL be re-initialised to J on entering IDLE, so each packet starts from J.
REQ-025 Packet line sequence: outEN rises with first encoded bit, falls on the edge ending EOP_J; total EOP = 3 cycles (SE0, SE0, J).
REQ-026 dataOutP=dataOutN=1 SHALL never be driven.

Reset
REQ-027 With RST=1 at a clock edge: state=IDLE, outEN=0, line=J, busy=0, eopDone=0, NRZI level=J.
REQ-028 RST SHALL take priority over all inputs, including mid-packet and mid-EOP; eopDone SHALL NOT pulse after a reset-aborted EOP.

Verification
REQ-029 SYNC: txActive=1 with dataIn 0,0,0,0,0,0,0,1 from IDLE, FS -> line K,J,K,J,K,J,K,K; outEN=1 for all 8 cycles.
REQ-030 After SYNC, dataIn 1,1,0 then sendEOP pulse -> line K,K,J, then SE0,SE0,J, then IDLE J with outEN=0 and eopDone=1 for one cycle.
REQ-031 Stall: TX at K, txActive=0 for 3 cycles then dataIn=0 -> line K,K,K,J; outEN stays 1.
REQ-032 sendEOP and txActive=1,dataIn=0 same cycle -> no toggle, SE0 next; sendEOP alone in IDLE -> no outEN, no eopDone.
REQ-033 RST asserted during EOP_SE0B -> next cycle IDLE, outEN=0, line J, eopDone=0; USE_LOW_SPEED=1 repeat of REQ-029 -> P/N values swapped.
